// File: rtl/alu_pkg.sv
// ALU op codes and state encoding shared by the execute-stage
// multiply sequencer and its datapath.
package alu_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_ROL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NEGA = 3'd1,
        S_NEGB = 3'd2,
        S_ITER = 3'd3,
        S_NEGR = 3'd4,
        S_CHKS = 3'd5,
        S_DONE = 3'd6
    } state_e;

    // First state after operand capture (or after negating A).
    function automatic state_e entry_st(
        input logic neg_a,
        input logic neg_b,
        input logic b_zero
    );
        if (neg_a)       return S_NEGA;
        else if (neg_b)  return S_NEGB;
        else if (b_zero) return S_DONE;
        else             return S_ITER;
    endfunction

endpackage

// File: rtl/alu_mul_dp.sv
// Multiply datapath: operand/accumulator registers, shift-add
// step and the ALU operand mux driven while the sequencer owns it.
module alu_mul_dp
    import alu_pkg::*;
#(
    parameter int         WIDTH      = 16,
    parameter logic [2:0] ALU_OP_ADD = OP_ADD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  state_e           st_i,
    input  logic             signed_mode_i,
    input  logic [WIDTH-1:0] opA_i,
    input  logic [WIDTH-1:0] opB_i,
    input  logic [WIDTH-1:0] alu_out_i,
    input  logic             alu_ofl_i,
    output logic             alu_own_o,
    output logic [WIDTH-1:0] alu_A_o,
    output logic [WIDTH-1:0] alu_B_o,
    output logic [2:0]       alu_Op_o,
    output logic             alu_Cin_o,
    output logic             alu_invB_o,
    output logic [WIDTH-1:0] mplier_o,
    output logic [WIDTH-1:0] mplier_d_o,
    output logic [WIDTH-1:0] acc_d_o,
    output logic             ovf_d_o,
    output logic             neg_res_o,
    output logic             sgn_o
);

    localparam logic [WIDTH-1:0] MIN_NEG =
        {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             neg_q, neg_d;
    logic             sgn_q, sgn_d;

    always_comb begin
        alu_own_o  = 1'b0;
        alu_A_o    = '0;
        alu_B_o    = '0;
        alu_Op_o   = '0;
        alu_Cin_o  = 1'b0;
        alu_invB_o = 1'b0;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        neg_d      = neg_q;
        sgn_d      = sgn_q;
        if (load_i) begin
            mcand_d  = opA_i;
            mplier_d = opB_i;
            acc_d    = '0;
            ovf_d    = 1'b0;
            neg_d    = signed_mode_i
                     & (opA_i[WIDTH-1] ^ opB_i[WIDTH-1]);
            sgn_d    = signed_mode_i;
        end else begin
            unique case (st_i)
                S_NEGA: begin
                    alu_own_o  = 1'b1;
                    alu_B_o    = mcand_q;
                    alu_invB_o = 1'b1;
                    alu_Cin_o  = 1'b1;
                    alu_Op_o   = ALU_OP_ADD;
                    mcand_d    = alu_out_i;
                end
                S_NEGB: begin
                    alu_own_o  = 1'b1;
                    alu_B_o    = mplier_q;
                    alu_invB_o = 1'b1;
                    alu_Cin_o  = 1'b1;
                    alu_Op_o   = ALU_OP_ADD;
                    mplier_d   = alu_out_i;
                end
                S_NEGR: begin
                    alu_own_o  = 1'b1;
                    alu_B_o    = acc_q;
                    alu_invB_o = 1'b1;
                    alu_Cin_o  = 1'b1;
                    alu_Op_o   = ALU_OP_ADD;
                    acc_d      = alu_out_i;
                end
                S_ITER: begin
                    if (mplier_q[0]) begin
                        alu_own_o = 1'b1;
                        alu_A_o   = acc_q;
                        alu_B_o   = mcand_q;
                        alu_Op_o  = ALU_OP_ADD;
                        acc_d     = alu_out_i;
                        ovf_d     = ovf_d | alu_ofl_i;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    // A set bit shifted out still has multiplier
                    // bits left to weight it: product exceeds WIDTH.
                    if (mcand_q[WIDTH-1] && mplier_d != '0)
                        ovf_d = 1'b1;
                    if (mplier_d == '0 && sgn_q
                        && acc_d[WIDTH-1]
                        && !(acc_d == MIN_NEG && neg_q))
                        ovf_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            sgn_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            sgn_q    <= sgn_d;
        end
    end

    assign mplier_o   = mplier_q;
    assign mplier_d_o = mplier_d;
    assign acc_d_o    = acc_d;
    assign ovf_d_o    = ovf_d;
    assign neg_res_o  = neg_q;
    assign sgn_o      = sgn_q;

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle 16x16 MUL sequencer that borrows the execute ALU,
// stalling the pipeline while it owns the operand mux.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int         WIDTH      = 16,
    parameter logic [2:0] ALU_OP_ADD = OP_ADD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             kill,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_ofl,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_Op,
    output logic             alu_Cin,
    output logic             alu_invB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             ovf
);

    state_e           st_q, st_d, post;
    logic             busy_q, done_q, ovf_q;
    logic [WIDTH-1:0] product_q;
    logic             load;
    logic [WIDTH-1:0] mplier, mplier_nx, acc_nx;
    logic             ovf_nx, neg_res, sgn;

    assign load = (st_q == S_IDLE) & start & ~kill;

    alu_mul_dp #(
        .WIDTH      (WIDTH),
        .ALU_OP_ADD (ALU_OP_ADD)
    ) u_dp (
        .clk           (clk),
        .rst           (rst),
        .load_i        (load),
        .st_i          (st_q),
        .signed_mode_i (signed_mode),
        .opA_i         (opA),
        .opB_i         (opB),
        .alu_out_i     (alu_out),
        .alu_ofl_i     (alu_ofl),
        .alu_own_o     (alu_own),
        .alu_A_o       (alu_A),
        .alu_B_o       (alu_B),
        .alu_Op_o      (alu_Op),
        .alu_Cin_o     (alu_Cin),
        .alu_invB_o    (alu_invB),
        .mplier_o      (mplier),
        .mplier_d_o    (mplier_nx),
        .acc_d_o       (acc_nx),
        .ovf_d_o       (ovf_nx),
        .neg_res_o     (neg_res),
        .sgn_o         (sgn)
    );

    // The signed range check is folded into the last ITER cycle,
    // so a non-negated signed result goes straight to DONE.
    assign post = neg_res ? S_NEGR : S_DONE;

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            S_IDLE: if (load)
                st_d = entry_st(signed_mode & opA[WIDTH-1],
                                signed_mode & opB[WIDTH-1],
                                opB == '0);
            S_NEGA:
                st_d = entry_st(1'b0, sgn & mplier[WIDTH-1],
                                mplier == '0);
            S_NEGB:
                st_d = (mplier_nx == '0) ? post : S_ITER;
            S_ITER: if (mplier_nx == '0) st_d = post;
            S_NEGR, S_CHKS: st_d = S_DONE;
            S_DONE: st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
        if (kill && st_q != S_IDLE) st_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            st_q   <= st_d;
            busy_q <= (st_d != S_IDLE);
            done_q <= (st_d == S_DONE);
            if (st_d == S_DONE) begin
                product_q <= acc_nx;
                ovf_q     <= ovf_nx;
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a stand-in execute ALU
// and an arithmetic reference model of signed/unsigned MUL.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst, start, signed_mode, kill;
    logic [15:0] opA, opB, alu_out, alu_A, alu_B, product;
    logic        alu_ofl, alu_own, alu_Cin, alu_invB;
    logic        busy, done, ovf;
    logic [2:0]  alu_Op;
    logic [16:0] alu_sum;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    // Stand-in ALU: add/sub with carry-out; other ops give XOR.
    always_comb begin
        alu_sum = {1'b0, alu_A}
                + {1'b0, (alu_invB ? ~alu_B : alu_B)}
                + {16'd0, alu_Cin};
        if (alu_Op == 3'b100) begin
            alu_out = alu_sum[15:0];
            alu_ofl = alu_sum[16];
        end else begin
            alu_out = alu_A ^ alu_B;
            alu_ofl = 1'b0;
        end
    end

    alu_mul_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .kill        (kill),
        .opA         (opA),
        .opB         (opB),
        .alu_out     (alu_out),
        .alu_ofl     (alu_ofl),
        .alu_own     (alu_own),
        .alu_A       (alu_A),
        .alu_B       (alu_B),
        .alu_Op      (alu_Op),
        .alu_Cin     (alu_Cin),
        .alu_invB    (alu_invB),
        .busy        (busy),
        .done        (done),
        .product     (product),
        .ovf         (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         input logic s, output logic [15:0] p,
                         output logic o, output int lat,
                         output int own, output bit lat_chk);
        logic        na, nb, neg;
        logic [15:0] ma, mb;
        logic [31:0] mag, full;
        int          msb;
        na   = s & a[15];
        nb   = s & b[15];
        neg  = na ^ nb;
        ma   = na ? (~a + 16'd1) : a;
        mb   = nb ? (~b + 16'd1) : b;
        mag  = {16'd0, ma} * {16'd0, mb};
        full = {16'd0, a} * {16'd0, b};
        p    = full[15:0];
        o    = (mag > 32'hFFFF)
            || (s && mag > 32'h7FFF && !(mag == 32'h8000 && neg));
        msb = 0;
        for (int i = 0; i < 16; i++) if (mb[i]) msb = i;
        if (mb == 16'd0)
            lat = 1 + int'(na);
        else
            lat = msb + 2 + int'(na) + int'(nb) + int'(neg);
        own = int'(na) + int'(nb) + $countones(mb)
            + ((mb != 16'd0 && neg) ? 1 : 0);
        lat_chk = !(s && !neg && mb != 16'd0);
    endtask

    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           input logic s);
        logic [15:0] ep;
        logic        eo;
        int          elat, eown, cyc, own, leak, nb;
        bit          lat_chk;
        model(a, b, s, ep, eo, elat, eown, lat_chk);
        @(negedge clk);
        opA = a; opB = b; signed_mode = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        opA = 16'($urandom);
        opB = 16'($urandom);
        signed_mode = 1'($urandom);
        cyc = 1; own = 0; leak = 0; nb = 0;
        while (done !== 1'b1 && cyc < 64) begin
            if (alu_own === 1'b1) own++;
            else if ({alu_A, alu_B, alu_Op, alu_Cin, alu_invB} !== '0)
                leak++;
            if (busy !== 1'b1) nb++;
            @(negedge clk);
            cyc++;
        end
        chk("done", done, 1);
        chk("busy_at_done", busy, 1);
        chk("product", product, ep);
        chk("ovf", ovf, eo);
        chk("alu_own_cycles", own, eown);
        chk("alu_idle_drive", leak, 0);
        chk("busy_gap", nb, 0);
        if (lat_chk) chk("latency", cyc, elat);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_clear", busy, 0);
        chk("product_hold", product, ep);
    endtask

    initial begin
        int cyc, seen;
        logic [15:0] ra, rb;
        rst = 1'b1; start = 1'b0; kill = 1'b0;
        signed_mode = 1'b0; opA = '0; opB = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_own", alu_own, 0);
        chk("rst_drives", {alu_A, alu_B, alu_Op, alu_Cin, alu_invB}, 0);
        rst = 1'b0;

        run_mul(16'h0003, 16'h0005, 1'b0);
        run_mul(16'h1234, 16'h0000, 1'b0);
        run_mul(16'hFFFD, 16'h0005, 1'b1);
        run_mul(16'h0100, 16'h0080, 1'b1);
        run_mul(16'hFF80, 16'h0100, 1'b1);
        run_mul(16'h8000, 16'h0002, 1'b0);
        run_mul(16'hFFFF, 16'hFFFF, 1'b0);
        run_mul(16'h0005, 16'hFFFD, 1'b1);
        run_mul(16'hFFFB, 16'hFFFD, 1'b1);
        run_mul(16'h0001, 16'h8000, 1'b1);
        run_mul(16'h8000, 16'h0000, 1'b1);

        // kill in the second ITER cycle
        run_mul(16'h0003, 16'h0005, 1'b0);
        @(negedge clk);
        opA = 16'h0009; opB = 16'h000B; signed_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", busy, 0);
        chk("kill_done", done, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("kill_no_done", seen, 0);
        chk("kill_product", product, 16'h000F);

        // start while busy is ignored
        @(negedge clk);
        opA = 16'h0003; opB = 16'h0005; signed_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        opA = 16'h0007; opB = 16'h0009; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 3;
        while (done !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        chk("busy_start_latency", cyc, 4);
        chk("busy_start_product", product, 16'h000F);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy === 1'b1) seen++;
        end
        chk("busy_start_dropped", seen, 0);

        // kill and start together in IDLE: start is dropped
        @(negedge clk);
        opA = 16'h0003; opB = 16'h0005; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        chk("kill_start_busy", busy, 0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("kill_start_no_done", seen, 0);

        // reset in the middle of ITER
        run_mul(16'hFFFF, 16'hFFFF, 1'b0);
        @(negedge clk);
        opA = 16'h0007; opB = 16'h00FF; signed_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_product", product, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_own", alu_own, 0);
        chk("midrst_drives",
            {alu_A, alu_B, alu_Op, alu_Cin, alu_invB}, 0);

        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 2) == 0) rb = rb & 16'h00FF;
            if ($urandom_range(0, 5) == 0) rb = 16'h0000;
            run_mul(ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
